ibex_register_file_mp: RTL and testbench
========================================

# ibex_register_file_mp

Multi-ported, parametrised flip-flop register file for the Ibex core, generalising the single-write-port FF register file. It provides a configurable number of read ports and write ports, optional same-cycle write-to-read bypass, a per-register pending-write scoreboard, and a registered write-conflict/illegal-address error flag. It sits between ID (read and scoreboard reserve) and WB (write ports, e.g. ALU result plus late load data).

## Interface
- RV32E, 0, 1 gives 16 architectural registers; 0 gives 32.
- DataWidth, 32, register width in bits.
- NumReadPorts, 3, number of read ports (1..4).
- NumWritePorts, 2, number of write ports (1..3); a higher index has higher priority.
- WriteBypass, 1, 1 forwards same-cycle write data to the read ports.
- Scoreboard, 1, 1 enables pending-write tracking; 0 ties all busy outputs to 0.
- WordZeroVal, '0, reset value of all registers and the read value of r0.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- raddr_i  in  NumReadPorts*5  read addresses; port k uses bits [5k+4:5k].
- rdata_o  out  NumReadPorts*DataWidth  read data, combinational.
- rd_busy_o  out  NumReadPorts  1 when the addressed register has a pending write.
- waddr_i  in  NumWritePorts*5  write addresses.
- wdata_i  in  NumWritePorts*DataWidth  write data.
- we_i  in  NumWritePorts  write enables.
- sb_set_i  in  1  reserve register sb_addr_i as pending.
- sb_addr_i  in  5  scoreboard reserve address.
- err_o  out  1  one-cycle pulse, registered: write conflict or illegal address in the previous cycle.

## Operation
- Storage: registers 1..N-1 are flops, with N = 16 when RV32E=1 and N = 32 otherwise. r0 has no storage. Reads of r0 always return WordZeroVal. Writes to r0 are discarded and never bypassed.
- Write: register i loads from the highest-index port j that has we_i[j]=1 and waddr j equal to i.
- Conflict: two or more enabled ports target the same nonzero address in one cycle. The highest index wins, and err_o=1 on the next cycle.
- Illegal address (RV32E=1 only): an address with bit 4 set on an enabled write port, on sb_set_i, or on a read port.
  - Writes and reserves to such an address are dropped.
  - Reads of such an address return WordZeroVal with rd_busy_o=0.
  - An illegal write or reserve sets err_o on the next cycle. An illegal read does not.
- Read: rdata_o[k] = stored value of raddr k.
  - With WriteBypass=1, a same-cycle enabled write to raddr k (nonzero, legal) is forwarded instead.
  - When several ports hit, the highest-index port is forwarded.
- Scoreboard: one sb_q bit per register; bit 0 is constant 0.
  - Clear: an enabled, legal write to register i clears sb_q[i] next cycle. Any port clears it, including a losing conflict port.
  - Set: sb_set_i with nonzero legal sb_addr_i sets sb_q[sb_addr_i] next cycle.
  - Simultaneous set and clear of the same register: set wins, so the bit stays 1.
  - rd_busy_o[k] = sb_q[raddr k], except that with WriteBypass=1 it is 0 when a same-cycle write hits raddr k and there is no simultaneous set.
  - A sb_set_i on the same register does not affect rd_busy_o in the current cycle; it takes effect next cycle.
- Reset (rst_i=1 at an edge):
  - All registers are set to WordZeroVal, all sb_q bits to 0, and err_o to 0.
  - Writes and sets in that cycle are ignored.
  - Reset has priority over every other event.

## Timing
- Read latency is 0 cycles (combinational from raddr_i and, with bypass, from the write inputs).
- Without bypass, a written value becomes visible on the read ports the cycle after we_i.
- Scoreboard set and clear take effect the cycle after the edge.
- err_o is high exactly one cycle after the offending cycle. Back-to-back offending cycles keep it high continuously.
- Values after reset: rdata_o = WordZeroVal for all addresses, rd_busy_o = 0, err_o = 0.
- No handshakes; every input is sampled every cycle.

## Test plan
- Reset, then write 0xDEADBEEF to x5 via port 0, then read x5 on all ports next cycle -> all ports return 0xDEADBEEF.
- Port 0 writes x7=0x11 and port 1 writes x7=0x22 in the same cycle -> x7 = 0x22 afterwards; err_o=1 for exactly one cycle, then 0.
- WriteBypass=1: write x3=0xA5A5 while raddr 0 = 3 -> rdata_o[0]=0xA5A5 in the same cycle. WriteBypass=0: old value that cycle, 0xA5A5 the next.
- sb_set_i on x9 -> rd_busy_o=1 on reads of x9 from the next cycle. A later write to x9 clears busy (same cycle with bypass). Simultaneous set and write to x9 -> busy remains 1.
- Write 0xFFFF to x0 and sb_set_i with x0 -> reads of x0 return WordZeroVal, busy 0, err_o 0.
- RV32E=1: write to address 17 -> dropped, err_o pulse; reading 17 returns WordZeroVal. Assert rst_i mid-run with pending bits set -> next cycle all registers read 0 and all busy outputs are 0.

Source files
------------

// File: rtl/ibex_register_file_mp.sv
// Multi-ported flip-flop register file with write bypass, pending-write scoreboard
// and a registered write-conflict / illegal-address error flag.
module ibex_register_file_mp #(
    parameter bit                    RV32E         = 1'b0,
    parameter int                    DataWidth     = 32,
    parameter int                    NumReadPorts  = 3,
    parameter int                    NumWritePorts = 2,
    parameter bit                    WriteBypass   = 1'b1,
    parameter bit                    Scoreboard    = 1'b1,
    parameter logic [DataWidth-1:0]  WordZeroVal   = '0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumReadPorts*5-1:0]         raddr_i,
    output logic [NumReadPorts*DataWidth-1:0] rdata_o,
    output logic [NumReadPorts-1:0]           rd_busy_o,
    input  logic [NumWritePorts*5-1:0]        waddr_i,
    input  logic [NumWritePorts*DataWidth-1:0] wdata_i,
    input  logic [NumWritePorts-1:0]          we_i,
    input  logic                              sb_set_i,
    input  logic [4:0]                        sb_addr_i,
    output logic                              err_o
);

    localparam int NumRegs = RV32E ? 16 : 32;
    localparam int AddrW   = RV32E ? 4 : 5;

    // Only RV32E has addresses outside the implemented register range.
    function automatic logic is_illegal(input logic [4:0] a);
        return (RV32E != 1'b0) && a[4];
    endfunction

    logic [DataWidth-1:0] r_rf [NumRegs];
    logic [NumRegs-1:0]   r_sb;
    logic                 r_err;

    logic [4:0]           w_waddr [NumWritePorts];
    logic [DataWidth-1:0] w_wdata [NumWritePorts];
    logic [NumWritePorts-1:0] w_wlegal;
    logic [NumWritePorts-1:0] w_willegal;

    logic [NumRegs-1:0]   w_wen;
    logic [NumRegs-1:0]   w_conf;
    logic [DataWidth-1:0] w_wsel_data [NumRegs];

    logic                 w_sb_set;
    logic                 w_sb_illegal;
    logic                 w_err_next;

    // Per write port decode: legal writes exclude r0 and out-of-range targets.
    generate
        for (genvar gi = 0; gi < NumWritePorts; gi++) begin : g_wport
            assign w_waddr[gi]    = waddr_i[5*gi +: 5];
            assign w_wdata[gi]    = wdata_i[DataWidth*gi +: DataWidth];
            assign w_wlegal[gi]   = we_i[gi] && (w_waddr[gi] != 5'd0) && !is_illegal(w_waddr[gi]);
            assign w_willegal[gi] = we_i[gi] && is_illegal(w_waddr[gi]);
        end
    endgenerate

    // Per register write select: the highest-index hitting port wins.
    generate
        for (genvar gi = 0; gi < NumRegs; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign w_wen[gi]       = 1'b0;
                assign w_conf[gi]      = 1'b0;
                assign w_wsel_data[gi] = WordZeroVal;
            end else begin : g_flop
                logic [NumWritePorts-1:0] w_hit;
                logic [DataWidth-1:0]     w_data;

                always_comb begin
                    w_hit  = '0;
                    w_data = w_wdata[0];
                    for (int j = 0; j < NumWritePorts; j++) begin
                        if (w_wlegal[j] && (w_waddr[j] == 5'(gi))) begin
                            w_hit[j] = 1'b1;
                            w_data   = w_wdata[j];
                        end
                    end
                end

                assign w_wen[gi]       = |w_hit;
                assign w_conf[gi]      = (w_hit & (w_hit - 1'b1)) != '0;
                assign w_wsel_data[gi] = w_data;
            end
        end
    endgenerate

    assign w_sb_set     = Scoreboard && sb_set_i && (sb_addr_i != 5'd0) && !is_illegal(sb_addr_i);
    assign w_sb_illegal = sb_set_i && is_illegal(sb_addr_i);
    assign w_err_next   = (|w_conf) || (|w_willegal) || w_sb_illegal;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRegs; i++) begin
                r_rf[i] <= WordZeroVal;
            end
            r_sb  <= '0;
            r_err <= 1'b0;
        end else begin
            for (int i = 1; i < NumRegs; i++) begin
                if (w_wen[i]) begin
                    r_rf[i] <= w_wsel_data[i];
                end
                // A reservation in the same cycle as the write keeps the register pending.
                if (w_sb_set && (sb_addr_i == 5'(i))) begin
                    r_sb[i] <= 1'b1;
                end else if (w_wen[i]) begin
                    r_sb[i] <= 1'b0;
                end
            end
            r_err <= w_err_next;
        end
    end

    assign err_o = r_err;

    generate
        for (genvar gi = 0; gi < NumReadPorts; gi++) begin : g_rport
            logic [4:0]           w_raddr;
            logic [DataWidth-1:0] w_rd;
            logic                 w_busy;
            logic                 w_bhit;

            assign w_raddr = raddr_i[5*gi +: 5];

            always_comb begin
                w_rd   = r_rf[w_raddr[AddrW-1:0]];
                w_bhit = 1'b0;
                if (WriteBypass) begin
                    for (int j = 0; j < NumWritePorts; j++) begin
                        if (w_wlegal[j] && (w_waddr[j] == w_raddr)) begin
                            w_rd   = w_wdata[j];
                            w_bhit = 1'b1;
                        end
                    end
                end
                w_busy = Scoreboard ? r_sb[w_raddr[AddrW-1:0]] : 1'b0;
                if (w_bhit && !(w_sb_set && (sb_addr_i == w_raddr))) begin
                    w_busy = 1'b0;
                end
                if ((w_raddr == 5'd0) || is_illegal(w_raddr)) begin
                    w_rd   = WordZeroVal;
                    w_busy = 1'b0;
                end
            end

            assign rdata_o[DataWidth*gi +: DataWidth] = w_rd;
            assign rd_busy_o[gi]                      = w_busy;
        end
    endgenerate

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Directed bench: vector table on the default configuration plus hand sequences
// for reset priority and an RV32E instance without bypass.
module tb_ibex_register_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default configuration: RV32I, 3 read ports, 2 write ports, bypass on.
    logic        m_rst;
    logic [14:0] m_raddr;
    logic [95:0] m_rdata;
    logic [2:0]  m_busy;
    logic [9:0]  m_waddr;
    logic [63:0] m_wdata;
    logic [1:0]  m_we;
    logic        m_sb;
    logic [4:0]  m_sba;
    logic        m_err;

    ibex_register_file_mp dut (
        .clk_i(clk), .rst_i(m_rst), .raddr_i(m_raddr), .rdata_o(m_rdata),
        .rd_busy_o(m_busy), .waddr_i(m_waddr), .wdata_i(m_wdata), .we_i(m_we),
        .sb_set_i(m_sb), .sb_addr_i(m_sba), .err_o(m_err)
    );

    // RV32E instance without bypass.
    logic        e_rst;
    logic [14:0] e_raddr;
    logic [95:0] e_rdata;
    logic [2:0]  e_busy;
    logic [9:0]  e_waddr;
    logic [63:0] e_wdata;
    logic [1:0]  e_we;
    logic        e_sb;
    logic [4:0]  e_sba;
    logic        e_err;

    ibex_register_file_mp #(.RV32E(1'b1), .WriteBypass(1'b0)) dut_e (
        .clk_i(clk), .rst_i(e_rst), .raddr_i(e_raddr), .rdata_o(e_rdata),
        .rd_busy_o(e_busy), .waddr_i(e_waddr), .wdata_i(e_wdata), .we_i(e_we),
        .sb_set_i(e_sb), .sb_addr_i(e_sba), .err_o(e_err)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        sb;
        logic [4:0]  sba;
        logic [4:0]  ra0, ra1, ra2;
        logic [31:0] ed0, ed1, ed2;
        logic [2:0]  eb;
        logic        eerr;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(
        input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
        input logic [4:0] wa1, input logic [31:0] wd1,
        input logic sb, input logic [4:0] sba,
        input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2,
        input logic [31:0] ed0, input logic [31:0] ed1, input logic [31:0] ed2,
        input logic [2:0] eb, input logic eerr);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.sb = sb; v.sba = sba; v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2;
        v.ed0 = ed0; v.ed1 = ed1; v.ed2 = ed2; v.eb = eb; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic m_drive(input vec_t v);
        m_we    = v.we;
        m_waddr = {v.wa1, v.wa0};
        m_wdata = {v.wd1, v.wd0};
        m_sb    = v.sb;
        m_sba   = v.sba;
        m_raddr = {v.ra2, v.ra1, v.ra0};
    endtask

    task automatic e_drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                           input logic sb, input logic [4:0] sba,
                           input logic [4:0] ra0, input logic [4:0] ra1);
        e_we    = we;
        e_waddr = {5'd0, wa0};
        e_wdata = {32'd0, wd0};
        e_sb    = sb;
        e_sba   = sba;
        e_raddr = {5'd0, ra1, ra0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // idle
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0,  0, 5, 7,  0, 0, 0, 3'b000, 0));
        // write / readback and same-cycle bypass
        vecs.push_back(mk(2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0,  5, 5, 5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0,  5, 5, 5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 0));
        // conflict on x7: higher port wins, one-cycle error pulse
        vecs.push_back(mk(2'b11, 7, 32'h11, 7, 32'h22, 0, 0,  7, 0, 5,  32'h22, 0, 32'hDEADBEEF, 3'b000, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0,  7, 7, 7,  32'h22, 32'h22, 32'h22, 3'b000, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0,  7, 7, 7,  32'h22, 32'h22, 32'h22, 3'b000, 0));
        vecs.push_back(mk(2'b01, 3, 32'hA5A5, 0, 0, 0, 0,  3, 1, 2,  32'hA5A5, 0, 0, 3'b000, 0));
        // scoreboard on x9
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 1, 9,  9, 9, 3,  0, 0, 32'hA5A5, 3'b000, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0,  9, 9, 9,  0, 0, 0, 3'b111, 0));
        vecs.push_back(mk(2'b10, 0, 0, 9, 32'h99, 0, 0,  9, 8, 9,  32'h99, 0, 32'h99, 3'b000, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0,  9, 8, 9,  32'h99, 0, 32'h99, 3'b000, 0));
        vecs.push_back(mk(2'b01, 9, 32'h123, 0, 0, 1, 9,  9, 9, 9,  32'h123, 32'h123, 32'h123, 3'b000, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0,  9, 9, 9,  32'h123, 32'h123, 32'h123, 3'b111, 0));
        // r0 writes and reservations are discarded
        vecs.push_back(mk(2'b01, 0, 32'hFFFF, 0, 0, 1, 0,  0, 0, 0,  0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 3'b000, 0));
        // bypass clears busy only for the written register
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 1, 12,  12, 13, 9,  0, 0, 32'h123, 3'b100, 0));
        vecs.push_back(mk(2'b11, 12, 32'h5, 13, 32'h6, 0, 0,  12, 13, 9,  32'h5, 32'h6, 32'h123, 3'b100, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0,  12, 13, 9,  32'h5, 32'h6, 32'h123, 3'b100, 0));
        // back-to-back conflicts hold err high
        vecs.push_back(mk(2'b11, 20, 32'h1, 20, 32'h2, 0, 0,  20, 20, 20,  32'h2, 32'h2, 32'h2, 3'b000, 0));
        vecs.push_back(mk(2'b11, 20, 32'h3, 20, 32'h4, 0, 0,  20, 20, 20,  32'h4, 32'h4, 32'h4, 3'b000, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0,  20, 20, 20,  32'h4, 32'h4, 32'h4, 3'b000, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0,  20, 20, 20,  32'h4, 32'h4, 32'h4, 3'b000, 0));
        // conflicting writes to a pending register clear it
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 1, 21,  21, 0, 0,  0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0,  21, 0, 0,  0, 0, 0, 3'b001, 0));
        vecs.push_back(mk(2'b11, 21, 32'h7, 21, 32'h8, 0, 0,  21, 21, 21,  32'h8, 32'h8, 32'h8, 3'b000, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0,  21, 21, 21,  32'h8, 32'h8, 32'h8, 3'b000, 1));

        m_rst = 1'b1;
        e_rst = 1'b1;
        m_drive(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        e_drive(2'b00, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        m_rst = 1'b0;
        e_rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            m_drive(vecs[i]);
            @(negedge clk);
            $display("vec %0d: we=%b wa=%0d/%0d sb=%b/%0d ra=%0d,%0d,%0d rd=%h,%h,%h busy=%b err=%b",
                     i, vecs[i].we, vecs[i].wa0, vecs[i].wa1, vecs[i].sb, vecs[i].sba,
                     vecs[i].ra0, vecs[i].ra1, vecs[i].ra2,
                     m_rdata[31:0], m_rdata[63:32], m_rdata[95:64], m_busy, m_err);
            chk($sformatf("v%0d_rdata0", i), m_rdata[31:0],  vecs[i].ed0);
            chk($sformatf("v%0d_rdata1", i), m_rdata[63:32], vecs[i].ed1);
            chk($sformatf("v%0d_rdata2", i), m_rdata[95:64], vecs[i].ed2);
            chk($sformatf("v%0d_busy", i),   32'(m_busy),    32'(vecs[i].eb));
            chk($sformatf("v%0d_err", i),    32'(m_err),     32'(vecs[i].eerr));
            next_cycle();
        end

        // Reset takes priority over a pending error, a write and a reservation.
        m_drive(mk(2'b11, 22, 32'h1, 22, 32'h2, 1, 10, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        next_cycle();
        m_rst = 1'b1;
        m_drive(mk(2'b01, 5, 32'h1, 0, 0, 1, 11, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        next_cycle();
        m_rst = 1'b0;
        m_drive(mk(2'b00, 0, 0, 0, 0, 0, 0, 5, 9, 10, 0, 0, 0, 3'b000, 0));
        @(negedge clk);
        $display("reset: rd=%h,%h,%h busy=%b err=%b", m_rdata[31:0], m_rdata[63:32], m_rdata[95:64], m_busy, m_err);
        chk("rst_x5",   m_rdata[31:0],  32'h0);
        chk("rst_x9",   m_rdata[63:32], 32'h0);
        chk("rst_x10",  m_rdata[95:64], 32'h0);
        chk("rst_busy", 32'(m_busy),    32'h0);
        chk("rst_err",  32'(m_err),     32'h0);
        next_cycle();
        m_drive(mk(2'b00, 0, 0, 0, 0, 0, 0, 11, 12, 21, 0, 0, 0, 3'b000, 0));
        @(negedge clk);
        $display("reset2: rd=%h,%h,%h busy=%b", m_rdata[31:0], m_rdata[63:32], m_rdata[95:64], m_busy);
        chk("rst_x12",   m_rdata[63:32], 32'h0);
        chk("rst_x21",   m_rdata[95:64], 32'h0);
        chk("rst_busy2", 32'(m_busy),    32'h0);
        next_cycle();

        // RV32E, no bypass: old value visible in the write cycle.
        e_drive(2'b01, 3, 32'hA5A5, 0, 0, 3, 0);
        @(negedge clk);
        $display("e: write x3 rd0=%h", e_rdata[31:0]);
        chk("e_nobyp_same", e_rdata[31:0], 32'h0);
        next_cycle();
        e_drive(2'b00, 0, 0, 0, 0, 3, 0);
        @(negedge clk);
        $display("e: read x3 rd0=%h", e_rdata[31:0]);
        chk("e_nobyp_next", e_rdata[31:0], 32'hA5A5);
        next_cycle();

        // Illegal write to 17 is dropped and flagged; it must not alias x1.
        e_drive(2'b01, 17, 32'h55, 0, 0, 17, 1);
        @(negedge clk);
        $display("e: write x17 rd=%h,%h err=%b", e_rdata[31:0], e_rdata[63:32], e_err);
        chk("e_ill_rd_same", e_rdata[31:0], 32'h0);
        chk("e_ill_err_same", 32'(e_err),   32'h0);
        next_cycle();
        e_drive(2'b00, 0, 0, 0, 0, 17, 1);
        @(negedge clk);
        $display("e: read x17 rd=%h,%h err=%b", e_rdata[31:0], e_rdata[63:32], e_err);
        chk("e_ill_rd17", e_rdata[31:0],  32'h0);
        chk("e_ill_rd1",  e_rdata[63:32], 32'h0);
        chk("e_ill_err",  32'(e_err),     32'h1);
        next_cycle();

        // Illegal read alone does not raise err.
        e_drive(2'b00, 0, 0, 0, 0, 20, 0);
        @(negedge clk);
        $display("e: read x20 rd=%h err=%b", e_rdata[31:0], e_err);
        chk("e_ill_read", e_rdata[31:0], 32'h0);
        chk("e_err_clr",  32'(e_err),    32'h0);
        next_cycle();
        e_drive(2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        $display("e: idle err=%b", e_err);
        chk("e_rd_noerr", 32'(e_err), 32'h0);
        next_cycle();

        // Illegal reserve: dropped, flagged.
        e_drive(2'b00, 0, 0, 1, 18, 18, 2);
        next_cycle();
        e_drive(2'b00, 0, 0, 0, 0, 18, 2);
        @(negedge clk);
        $display("e: after sb x18 busy=%b err=%b", e_busy, e_err);
        chk("e_sbill_busy", 32'(e_busy), 32'h0);
        chk("e_sbill_err",  32'(e_err),  32'h1);
        next_cycle();

        // Scoreboard without bypass: busy clears only after the write edge.
        e_drive(2'b00, 0, 0, 1, 9, 9, 0);
        @(negedge clk);
        $display("e: sb x9 busy=%b err=%b", e_busy, e_err);
        chk("e_sb_same", 32'(e_busy), 32'h0);
        next_cycle();
        e_drive(2'b00, 0, 0, 0, 0, 9, 0);
        @(negedge clk);
        $display("e: read x9 busy=%b", e_busy);
        chk("e_sb_next", 32'(e_busy), 32'h1);
        next_cycle();
        e_drive(2'b01, 9, 32'h77, 0, 0, 9, 0);
        @(negedge clk);
        $display("e: write x9 rd=%h busy=%b", e_rdata[31:0], e_busy);
        chk("e_wr_busy", 32'(e_busy),    32'h1);
        chk("e_wr_rd",   e_rdata[31:0],  32'h0);
        next_cycle();
        e_drive(2'b00, 0, 0, 0, 0, 9, 0);
        @(negedge clk);
        $display("e: read x9 rd=%h busy=%b", e_rdata[31:0], e_busy);
        chk("e_clr_busy", 32'(e_busy),   32'h0);
        chk("e_clr_rd",   e_rdata[31:0], 32'h77);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
